// File: rtl/dram_cmd_sched_pkg.sv
// rtl/dram_cmd_sched_pkg.sv - command and state encodings for the DRAM command scheduler
//
// Purpose: encodings shared by the scheduler, its timer and the bench.
//   CMD_*  : values driven on the command bus.
//   ST_*   : scheduler FSM states.
//   wait_load() : load value for the shared wait timer so that the state
//                 following a wait begins exactly T cycles after the command.
package dram_cmd_sched_pkg;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FETCH = 4'd1;
  localparam logic [3:0] ST_LOAD  = 4'd2;
  localparam logic [3:0] ST_PRE   = 4'd3;
  localparam logic [3:0] ST_TRP   = 4'd4;
  localparam logic [3:0] ST_ACT   = 4'd5;
  localparam logic [3:0] ST_TRCD  = 4'd6;
  localparam logic [3:0] ST_CMD   = 4'd7;
  localparam logic [3:0] ST_REF   = 4'd8;
  localparam logic [3:0] ST_TRFC  = 4'd9;

  // The timer is loaded in the command cycle and the wait state exits in the
  // cycle its done flag is seen, so a T-cycle spacing needs a load of T-2.
  function automatic logic [7:0] wait_load(input int t);
    return (t >= 2) ? 8'(t - 2) : 8'd0;
  endfunction

endpackage

// File: rtl/dram_timer.sv
// rtl/dram_timer.sv - loadable 8-bit down-counter with done flag
//
// Purpose: saturating down-counter; done_o is high while the count is zero.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset, count <= RST_VAL
//   load_i      load load_val_i this cycle (takes priority over counting)
//   load_val_i  value to load
//   done_o      count has reached zero
module dram_timer #(
  parameter logic [7:0] RST_VAL = 8'd0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/dram_cmd_sched.sv
// rtl/dram_cmd_sched.sv - open-page DRAM command scheduler with periodic refresh
//
// Purpose: pops one request word at a time from the request FIFO and issues
//   ACT / RD / WR / PRE under an open-page policy, enforcing tRCD, tRP, tRAS,
//   tRFC and inserting a refresh every T_REFI cycles.
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   req_data_i    FIFO word: [MSB]=we, [COL_W+:ROW_W]=row, [COL_W-1:0]=col
//   empty_flag_i  FIFO empty
//   rd_en_o       FIFO pop strobe (one cycle per request)
//   cmd_o         NOP/ACT/RD/WR/PRE/REF
//   cmd_row_o     row during ACT, else 0
//   cmd_col_o     column during RD/WR, else 0
//   busy_o        high whenever the FSM is not idle
module dram_cmd_sched
  import dram_cmd_sched_pkg::*;
#(
  parameter int ROW_W  = 4,
  parameter int COL_W  = 3,
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_RAS  = 6,
  parameter int T_RFC  = 8,
  parameter int T_REFI = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ROW_W+COL_W:0]   req_data_i,
  input  logic                   empty_flag_i,
  output logic                   rd_en_o,
  output logic [2:0]             cmd_o,
  output logic [ROW_W-1:0]       cmd_row_o,
  output logic [COL_W-1:0]       cmd_col_o,
  output logic                   busy_o
);

  localparam int REQ_W = 1 + ROW_W + COL_W;

  logic [3:0]       state_q, state_d;
  logic [REQ_W-1:0] req_q, req_d;
  logic             row_open_q, row_open_d;
  logic [ROW_W-1:0] open_row_q, open_row_d;
  logic             ref_pend_q, ref_pend_d;
  logic             req_live_q, req_live_d;

  logic       wait_load_en, wait_done, tras_done, refi_done, pre_go;
  logic [7:0] wait_val;

  // PRE is held in its state (cmd NOP) until the row has been open for tRAS.
  assign pre_go = (state_q == ST_PRE) && tras_done;

  assign wait_load_en = (state_q == ST_ACT) || (state_q == ST_REF) || pre_go;

  always_comb begin
    wait_val = wait_load(T_RP);
    if (state_q == ST_ACT) wait_val = wait_load(T_RCD);
    if (state_q == ST_REF) wait_val = wait_load(T_RFC);
  end

  dram_timer #(.RST_VAL(8'd0)) u_wait (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(wait_load_en),
    .load_val_i(wait_val), .done_o(wait_done)
  );

  dram_timer #(.RST_VAL(8'd0)) u_tras (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(state_q == ST_ACT),
    .load_val_i(8'(T_RAS - 1)), .done_o(tras_done)
  );

  // Free-running: reloads itself in the cycle it reaches zero.
  dram_timer #(.RST_VAL(8'(T_REFI - 1))) u_trefi (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(refi_done),
    .load_val_i(8'(T_REFI - 1)), .done_o(refi_done)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    ref_pend_d = ref_pend_q | refi_done;
    req_live_d = req_live_q;
    case (state_q)
      ST_IDLE: begin
        if (ref_pend_q)         state_d = row_open_q ? ST_PRE : ST_REF;
        else if (!empty_flag_i) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        req_d      = req_data_i;
        req_live_d = 1'b1;
        if (row_open_q && (req_data_i[COL_W +: ROW_W] == open_row_q)) state_d = ST_CMD;
        else if (!row_open_q)                                        state_d = ST_ACT;
        else                                                         state_d = ST_PRE;
      end
      ST_PRE: begin
        if (tras_done) begin
          row_open_d = 1'b0;
          // A precharge for a row miss must finish its request before any
          // pending refresh is taken; only a refresh-initiated PRE goes to REF.
          if (T_RP > 1) state_d = ST_TRP;
          else          state_d = req_live_q ? ST_ACT : ST_REF;
        end
      end
      ST_TRP: begin
        if (wait_done) state_d = req_live_q ? ST_ACT : ST_REF;
      end
      ST_ACT: begin
        row_open_d = 1'b1;
        open_row_d = req_q[COL_W +: ROW_W];
        state_d    = (T_RCD > 1) ? ST_TRCD : ST_CMD;
      end
      ST_TRCD: begin
        if (wait_done) state_d = ST_CMD;
      end
      ST_CMD: begin
        req_live_d = 1'b0;
        state_d    = ST_IDLE;
      end
      ST_REF: begin
        // An expiry landing in the REF cycle starts a fresh interval.
        ref_pend_d = refi_done;
        state_d    = (T_RFC > 1) ? ST_TRFC : ST_IDLE;
      end
      ST_TRFC: begin
        if (wait_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      ref_pend_q <= 1'b0;
      req_live_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      ref_pend_q <= ref_pend_d;
      req_live_q <= req_live_d;
    end
  end

  assign rd_en_o = (state_q == ST_FETCH);
  assign busy_o  = (state_q != ST_IDLE);

  always_comb begin
    cmd_o = CMD_NOP;
    case (state_q)
      ST_ACT:  cmd_o = CMD_ACT;
      ST_CMD:  cmd_o = req_q[REQ_W-1] ? CMD_WR : CMD_RD;
      ST_REF:  cmd_o = CMD_REF;
      ST_PRE:  cmd_o = pre_go ? CMD_PRE : CMD_NOP;
      default: cmd_o = CMD_NOP;
    endcase
  end

  assign cmd_row_o = (state_q == ST_ACT) ? req_q[COL_W +: ROW_W] : '0;
  assign cmd_col_o = (state_q == ST_CMD) ? req_q[COL_W-1:0] : '0;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// tb/tb_dram_cmd_sched.sv - directed self-checking bench for dram_cmd_sched
module tb_dram_cmd_sched;
  import dram_cmd_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_data = 8'h00;
  logic       empty = 1'b1;
  logic       rd_en;
  logic [2:0] cmd;
  logic [3:0] cmd_row;
  logic [2:0] cmd_col;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_rel = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rd_en === 1'b1) rd_cnt = rd_cnt + 1;

  dram_cmd_sched dut (
    .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .empty_flag_i(empty),
    .rd_en_o(rd_en), .cmd_o(cmd), .cmd_row_o(cmd_row), .cmd_col_o(cmd_col),
    .busy_o(busy)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; empty = 1'b1; req_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rst_rel = cyc;
  endtask

  // FIFO with one word: presents it at the end of the pop cycle.
  task automatic fifo_push(input logic [7:0] w, input int limit, output int at);
    at = -1;
    empty = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rd_en === 1'b1) begin
        at = cyc; req_data = w; empty = 1'b1;
        break;
      end
    end
    empty = 1'b1;
  endtask

  task automatic next_cmd(input int limit, output int at, output logic [2:0] c,
                          output logic [3:0] r, output logic [2:0] col);
    at = -1; c = 3'd7; r = 4'd0; col = 3'd0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cmd !== CMD_NOP) begin
        at = cyc; c = cmd; r = cmd_row; col = cmd_col;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    checks++; if (cmd !== CMD_NOP) begin errors++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
    checks++; if (cmd_row !== 4'd0) begin errors++; $display("FAIL reset_cmd_row: got %0d expected 0", cmd_row); end
    checks++; if (cmd_col !== 3'd0) begin errors++; $display("FAIL reset_cmd_col: got %0d expected 0", cmd_col); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (rd_en !== 1'b0 || cmd !== CMD_NOP || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d: got rd_en=%b cmd=%0d busy=%b expected 0/0/0", i, rd_en, cmd, busy);
      end
    end
  endtask

  task automatic test_cold_read;
    int f, a, t, n0;
    logic [2:0] c, col;
    logic [3:0] r;
    n0 = rd_cnt;
    fifo_push(8'h5A, 20, f);
    checks++; if (f < 0) begin errors++; $display("FAIL cold_fetch: got no rd_en expected one pop"); end
    next_cmd(20, a, c, r, col);
    checks++; if (c !== CMD_ACT || r !== 4'hB || a != f + 2) begin errors++;
      $display("FAIL cold_act: got cmd=%0d row=%0d at %0d expected ACT row 11 at %0d", c, r, a, f + 2); end
    next_cmd(20, t, c, r, col);
    checks++; if (c !== CMD_RD || col !== 3'd2 || t != a + 3) begin errors++;
      $display("FAIL cold_rd: got cmd=%0d col=%0d at %0d expected RD col 2 at %0d", c, col, t, a + 3); end
    checks++; if (rd_cnt != n0 + 1) begin errors++; $display("FAIL cold_pop_count: got %0d expected %0d", rd_cnt - n0, 1); end
  endtask

  task automatic test_row_hit;
    int f, t;
    logic [2:0] c, col;
    logic [3:0] r;
    fifo_push(8'hDB, 20, f);
    checks++; if (f < 0) begin errors++; $display("FAIL hit_fetch: got no rd_en expected one pop"); end
    next_cmd(20, t, c, r, col);
    checks++; if (c !== CMD_WR || col !== 3'd3 || t != f + 2) begin errors++;
      $display("FAIL hit_wr: got cmd=%0d col=%0d at %0d expected WR col 3 at %0d", c, col, t, f + 2); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hit_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_row_miss;
    int f, a, t, p, a2, t2, n0;
    logic [2:0] c, col;
    logic [3:0] r;
    do_reset();
    n0 = rd_cnt;
    fifo_push(8'h5A, 20, f);
    next_cmd(20, a, c, r, col);
    next_cmd(20, t, c, r, col);
    fifo_push(8'h15, 20, f);
    next_cmd(30, p, c, r, col);
    checks++; if (c !== CMD_PRE || p < a + 6) begin errors++;
      $display("FAIL miss_pre: got cmd=%0d at %0d expected PRE at >= %0d", c, p, a + 6); end
    next_cmd(20, a2, c, r, col);
    checks++; if (c !== CMD_ACT || r !== 4'd2 || a2 != p + 3) begin errors++;
      $display("FAIL miss_act: got cmd=%0d row=%0d at %0d expected ACT row 2 at %0d", c, r, a2, p + 3); end
    next_cmd(20, t2, c, r, col);
    checks++; if (c !== CMD_RD || col !== 3'd5 || t2 != a2 + 3) begin errors++;
      $display("FAIL miss_rd: got cmd=%0d col=%0d at %0d expected RD col 5 at %0d", c, col, t2, a2 + 3); end
    checks++; if (rd_cnt != n0 + 2) begin errors++; $display("FAIL miss_pop_count: got %0d expected %0d", rd_cnt - n0, 2); end
  endtask

  // Row 2 is left open by the row-miss test; its reset restarted the refresh counter.
  task automatic test_refresh;
    int pre_at, ref_at, rd_at, a, t, x;
    logic [2:0] c, col;
    logic [3:0] r;
    pre_at = -1; ref_at = -1; rd_at = -1;
    for (int i = 0; i < 100 && cyc < rst_rel + 64; i++) @(negedge clk);
    empty = 1'b0;
    req_data = 8'h00;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd === CMD_PRE && pre_at < 0) pre_at = cyc;
      if (cmd === CMD_REF && ref_at < 0) ref_at = cyc;
      if (rd_en === 1'b1) begin
        rd_at = cyc; req_data = 8'h27; empty = 1'b1;
        break;
      end
    end
    empty = 1'b1;
    checks++; if (pre_at != rst_rel + 65) begin errors++;
      $display("FAIL ref_pre: got PRE at %0d expected %0d", pre_at, rst_rel + 65); end
    checks++; if (ref_at < 0 || ref_at != pre_at + 3) begin errors++;
      $display("FAIL ref_issue: got REF at %0d expected %0d", ref_at, pre_at + 3); end
    checks++; if (rd_at < 0 || ref_at < 0 || rd_at != ref_at + 9) begin errors++;
      $display("FAIL ref_no_pop: got first rd_en at %0d expected %0d", rd_at, ref_at + 9); end
    next_cmd(20, a, c, r, col);
    checks++; if (c !== CMD_ACT || r !== 4'd4 || a != rd_at + 2) begin errors++;
      $display("FAIL ref_act_after: got cmd=%0d row=%0d at %0d expected ACT row 4 at %0d", c, r, a, rd_at + 2); end
    next_cmd(20, t, c, r, col);
    checks++; if (c !== CMD_RD || col !== 3'd7 || t != a + 3) begin errors++;
      $display("FAIL ref_rd_after: got cmd=%0d col=%0d at %0d expected RD col 7 at %0d", c, col, t, a + 3); end
    next_cmd(20, x, c, r, col);
    checks++; if (c !== 3'd7) begin errors++;
      $display("FAIL ref_pend_cleared: got cmd=%0d at %0d expected no command", c, x); end
  endtask

  task automatic test_reset_in_trcd;
    int f, a, t, x, n0;
    logic [2:0] c, col;
    logic [3:0] r;
    do_reset();
    fifo_push(8'h5A, 20, f);
    next_cmd(20, a, c, r, col);
    checks++; if (c !== CMD_ACT || r !== 4'hB) begin errors++;
      $display("FAIL rst_pre_act: got cmd=%0d row=%0d expected ACT row 11", c, r); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (cmd !== CMD_NOP || rd_en !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL rst_trcd_outputs: got cmd=%0d rd_en=%b busy=%b expected 0/0/0", cmd, rd_en, busy); end
    n0 = rd_cnt;
    next_cmd(6, x, c, r, col);
    checks++; if (c !== 3'd7 || rd_cnt != n0) begin errors++;
      $display("FAIL rst_abandon: got cmd=%0d pops=%0d expected no command and 0 pops", c, rd_cnt - n0); end
    fifo_push(8'hDB, 20, f);
    next_cmd(20, a, c, r, col);
    checks++; if (c !== CMD_ACT || r !== 4'hB || a != f + 2) begin errors++;
      $display("FAIL rst_row_closed: got cmd=%0d row=%0d at %0d expected ACT row 11 at %0d", c, r, a, f + 2); end
    next_cmd(20, t, c, r, col);
    checks++; if (c !== CMD_WR || col !== 3'd3 || t != a + 3) begin errors++;
      $display("FAIL rst_wr: got cmd=%0d col=%0d at %0d expected WR col 3 at %0d", c, col, t, a + 3); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_cold_read();
    test_row_hit();
    test_row_miss();
    test_refresh();
    test_reset_in_trcd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
